// File: rtl/shift_left_seq_if.sv
// shift_left_seq_if: operand/result bundle for shift_left_seq; the rot signal exists only when SHIFT_ROTATE_EN is defined
interface shift_left_seq_if #(parameter int WIDTH = 4, parameter int SHAMT_W = 3);
  logic start;
  logic [WIDTH-1:0] a;
  logic [SHAMT_W-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic carry;
  logic zero;
`ifdef SHIFT_ROTATE_EN
  logic rot;
  modport master (output start, a, b, rot, input busy, done, result, carry, zero);
  modport slave (input start, a, b, rot, output busy, done, result, carry, zero);
`else
  modport master (output start, a, b, input busy, done, result, carry, zero);
  modport slave (input start, a, b, output busy, done, result, carry, zero);
`endif
endinterface

// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle left shifter, one bit per clock with carry/zero flags; SHIFT_ROTATE_EN adds rotate mode
module shift_left_seq #(
  parameter int WIDTH = 4,
  parameter int SHAMT_W = 3
) (
  input logic clk,
  input logic rst,
  shift_left_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, fill, accept, shifting;
  assign accept = state_q == IDLE && bus.start;
  assign shifting = state_q == SHIFT;
`ifdef SHIFT_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_d = accept ? bus.rot : rot_q;
  assign fill = rot_q & result_q[WIDTH-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) rot_q <= 1'b0;
    else rot_q <= rot_d;
`else
  assign fill = 1'b0;
`endif
  always_comb begin
    state_d = state_q == IDLE ? (bus.start ? (bus.b != '0 ? SHIFT : DONE) : IDLE)
            : shifting ? (cnt_q == SHAMT_W'(1) ? DONE : SHIFT) : IDLE;
    result_d = accept ? bus.a : shifting ? {result_q[WIDTH-2:0], fill} : result_q;
    carry_d = accept ? 1'b0 : shifting ? result_q[WIDTH-1] : carry_q;
    cnt_d = accept ? bus.b : shifting ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      result_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  assign bus.carry = carry_q;
  assign bus.zero = result_q == '0;
endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed tests against a cycle-budget model of the shifter plus hand-computed literal checks
module tb_shift_left_seq;
  localparam int W = 4, S = 3;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  shift_left_seq_if #(.WIDTH(W), .SHAMT_W(S)) bus ();
  shift_left_seq #(.WIDTH(W), .SHAMT_W(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Result of shifting a by b one bit at a time, written as plain arithmetic
  function automatic void predict(input logic [W-1:0] a, input int b, input logic r,
                                  output logic [W-1:0] res, output logic c);
    longint x = longint'(a);
    int k;
    if (r) begin
      k = b % W;
      res = W'((x << k) | (x >> (W - k)));
      c = (b == 0) ? 1'b0 : res[0];
    end else begin
      res = (b >= W) ? '0 : W'(x << b);
      c = (b == 0 || b > W) ? 1'b0 : a[W-b];
    end
  endfunction
  int left = 0;
  logic [W-1:0] m_res = '0;
  logic m_carry = 1'b0;
  logic cur_rot;
`ifdef SHIFT_ROTATE_EN
  assign cur_rot = bus.rot;
`else
  assign cur_rot = 1'b0;
`endif
  always @(negedge clk) begin
    if (rst) begin
      left = 0;
      m_res = '0;
      m_carry = 1'b0;
    end
    chk("m_busy", {31'b0, bus.busy}, {31'b0, left > 0});
    chk("m_done", {31'b0, bus.done}, {31'b0, left == 1});
    if (left <= 1) begin
      chk("m_result", {28'b0, bus.result}, {28'b0, m_res});
      chk("m_carry", {31'b0, bus.carry}, {31'b0, m_carry});
      chk("m_zero", {31'b0, bus.zero}, {31'b0, m_res == '0});
    end
    if (left > 0) left--;
    else if (!rst && bus.start) begin
      left = int'(bus.b) + 1;
      predict(bus.a, int'(bus.b), cur_rot, m_res, m_carry);
    end
  end
  task automatic op(input logic [W-1:0] a, input logic [S-1:0] b, input logic r,
                    input logic [W-1:0] er, input logic ec);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = a; bus.b = b;
`ifdef SHIFT_ROTATE_EN
    bus.rot = r;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, int'(b) + (r & 1'b0));
    chk("result", {28'b0, bus.result}, {28'b0, er});
    chk("carry", {31'b0, bus.carry}, {31'b0, ec});
    chk("zero", {31'b0, bus.zero}, {31'b0, er == '0});
    @(posedge clk); #1;
    chk("done_pulse_len", {31'b0, bus.done}, 32'd0);
  endtask
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
`ifdef SHIFT_ROTATE_EN
    bus.rot = 1'b0;
`endif
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", {28'b0, bus.result}, 32'd0);
    chk("rst_zero", {31'b0, bus.zero}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    op(4'b0011, 3'd1, 1'b0, 4'b0110, 1'b0);
    op(4'b1001, 3'd1, 1'b0, 4'b0010, 1'b1);
    op(4'b1011, 3'd2, 1'b0, 4'b1100, 1'b0);
    op(4'b0101, 3'd0, 1'b0, 4'b0101, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_clear_result", {28'b0, bus.result}, 32'd0);
    chk("rst_clear_zero", {31'b0, bus.zero}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    op(4'b0001, 3'd4, 1'b0, 4'b0000, 1'b1);
    op(4'b1111, 3'd7, 1'b0, 4'b0000, 1'b0);
    op(4'b0110, 3'd3, 1'b0, 4'b0000, 1'b1);
    // start pulses while busy, including in the DONE cycle, must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 4'b0001; bus.b = 3'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1; bus.a = 4'b1111;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    chk("proto_done", {31'b0, bus.done}, 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("proto_ignored_busy", {31'b0, bus.busy}, 32'd0);
    chk("proto_result", {28'b0, bus.result}, 32'b1000);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 4'b0011; bus.b = 3'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_result", {28'b0, bus.result}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'b0, bus.done}, 32'd0);
    end
`ifdef SHIFT_ROTATE_EN
    op(4'b1001, 3'd1, 1'b1, 4'b0011, 1'b1);
    op(4'b1001, 3'd4, 1'b1, 4'b1001, 1'b1);
    op(4'b0110, 3'd6, 1'b1, 4'b1001, 1'b1);
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
